// File: rtl/regfile_wb_arbiter.sv
// Per-source FIFO and two-source round-robin writeback arbiter for the register file write port.
// Uncontended: accept at edge k, wr_en high after edge k+1. Ready comes only from the registered count.
module regfile_wb_fifo #(
  parameter int WIDTH     = 37,
  parameter int DEPTH     = 2,
  parameter int CNT_WIDTH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  logic                 pop,
  input  logic [WIDTH-1:0]     din,
  output logic [WIDTH-1:0]     head,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 ready,
  output logic                 nonempty
);
  localparam int PTR_WIDTH = $clog2(DEPTH);

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [PTR_WIDTH-1:0] wr_ptr;
  logic [PTR_WIDTH-1:0] rd_ptr;

  assign ready    = (count != CNT_WIDTH'(DEPTH));
  assign nonempty = (count != '0);
  assign head     = mem[rd_ptr];

  // Storage is not reset; a zero count makes every stale entry unreachable.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_WIDTH'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_WIDTH'(1);
      if (push && !pop)      count <= count + CNT_WIDTH'(1);
      else if (pop && !push) count <= count - CNT_WIDTH'(1);
    end
  end
endmodule

module regfile_wb_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  parameter int ADDR_WIDTH = $clog2(NUM_REGS),
  parameter int FIFO_DEPTH = 2,
  parameter int CNT_WIDTH  = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  src0_valid,
  output logic                  src0_ready,
  input  logic [ADDR_WIDTH-1:0] src0_addr,
  input  logic [DATA_WIDTH-1:0] src0_data,
  input  logic                  src1_valid,
  output logic                  src1_ready,
  input  logic [ADDR_WIDTH-1:0] src1_addr,
  input  logic [DATA_WIDTH-1:0] src1_data,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic [CNT_WIDTH-1:0]  src0_count,
  output logic [CNT_WIDTH-1:0]  src1_count
);
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } wb_t;

  wb_t  in0, in1, head0, head1;
  logic push0, push1, avail0, avail1;
  logic gnt0, gnt1;
  logic last_grant;

  assign in0   = '{addr: src0_addr, data: src0_data};
  assign in1   = '{addr: src1_addr, data: src1_data};
  assign push0 = src0_valid && src0_ready;
  assign push1 = src1_valid && src1_ready;

  regfile_wb_fifo #(.WIDTH($bits(wb_t)), .DEPTH(FIFO_DEPTH), .CNT_WIDTH(CNT_WIDTH)) u_fifo0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push0),
    .pop      (gnt0),
    .din      (in0),
    .head     (head0),
    .count    (src0_count),
    .ready    (src0_ready),
    .nonempty (avail0)
  );

  regfile_wb_fifo #(.WIDTH($bits(wb_t)), .DEPTH(FIFO_DEPTH), .CNT_WIDTH(CNT_WIDTH)) u_fifo1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push1),
    .pop      (gnt1),
    .din      (in1),
    .head     (head1),
    .count    (src1_count),
    .ready    (src1_ready),
    .nonempty (avail1)
  );

  // On a tie the source that did not win last time is granted.
  assign gnt0 = avail0 && (!avail1 || last_grant);
  assign gnt1 = avail1 && (!avail0 || !last_grant);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      last_grant <= 1'b1;
    end else begin
      wr_en <= gnt0 || gnt1;
      if (gnt0) begin
        wr_addr    <= head0.addr;
        wr_data    <= head0.data;
        last_grant <= 1'b0;
      end else if (gnt1) begin
        wr_addr    <= head1.addr;
        wr_data    <= head1.data;
        last_grant <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: reset, latency, round-robin, backpressure, ordering.
module tb_regfile_wb_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          src0_valid = 1'b0, src1_valid = 1'b0;
  logic          src0_ready, src1_ready;
  logic [AW-1:0] src0_addr = '0, src1_addr = '0;
  logic [DW-1:0] src0_data = '0, src1_data = '0;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [CW-1:0] src0_count, src1_count;

  int checks = 0;
  int fails  = 0;

  logic [AW-1:0] log_a [$];
  logic [DW-1:0] log_d [$];
  logic [DW-1:0] e0 [$];
  logic [DW-1:0] e1 [$];
  logic [DW-1:0] rf [32];
  logic          acc0, acc1;

  regfile_wb_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .src0_valid (src0_valid),
    .src0_ready (src0_ready),
    .src0_addr  (src0_addr),
    .src0_data  (src0_data),
    .src1_valid (src1_valid),
    .src1_ready (src1_ready),
    .src1_addr  (src1_addr),
    .src1_data  (src1_data),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .src0_count (src0_count),
    .src1_count (src1_count)
  );

  always #5 clk = ~clk;

  // Register file model plus a log of every committed write.
  always @(posedge clk) begin
    if (rst_n === 1'b1 && wr_en === 1'b1) begin
      log_a.push_back(wr_addr);
      log_d.push_back(wr_data);
      rf[wr_addr] <= wr_data;
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running want finished");
    $fatal(1, "timeout");
  end

  // Decide acceptance mid-cycle, then advance to 1 time unit after the next rising edge.
  task automatic step;
    @(negedge clk);
    acc0 = src0_valid && src0_ready;
    acc1 = src1_valid && src1_ready;
    if (acc0) e0.push_back(src0_data);
    if (acc1) e1.push_back(src1_data);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    src0_valid = 1'b0;
    src1_valid = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    log_a.delete(); log_d.delete(); e0.delete(); e1.delete();
  endtask

  task automatic test_reset;
    do_reset;
    src0_valid = 1'b1; src0_addr = 5'd9; src0_data = 32'h1111_2222;
    step;
    step;
    src0_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (wr_en !== 1'b0)      begin fails++; $display("FAIL reset_wr_en: got %b want 0", wr_en); end
    checks++; if (wr_addr !== '0)      begin fails++; $display("FAIL reset_wr_addr: got %0d want 0", wr_addr); end
    checks++; if (wr_data !== '0)      begin fails++; $display("FAIL reset_wr_data: got %h want 0", wr_data); end
    checks++; if (src0_count !== '0)   begin fails++; $display("FAIL reset_count0: got %0d want 0", src0_count); end
    checks++; if (src1_count !== '0)   begin fails++; $display("FAIL reset_count1: got %0d want 0", src1_count); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (src0_ready !== 1'b1 || src1_ready !== 1'b1) begin
        fails++; $display("FAIL reset_ready: got %b%b want 11", src0_ready, src1_ready);
      end
    end
    #3 rst_n = 1'b1;
    log_a.delete(); log_d.delete(); e0.delete(); e1.delete();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++; if (wr_en !== 1'b0) begin fails++; $display("FAIL post_reset_wr_en: cycle %0d got %b want 0", i, wr_en); end
    end
  endtask

  task automatic test_single_write;
    do_reset;
    src0_valid = 1'b1; src0_addr = 5'd5; src0_data = 32'hDEAD_BEEF;
    checks++; if (src0_count !== 2'd0) begin fails++; $display("FAIL single_count_pre: got %0d want 0", src0_count); end
    step;
    src0_valid = 1'b0;
    checks++; if (src0_count !== 2'd1) begin fails++; $display("FAIL single_count_k: got %0d want 1", src0_count); end
    checks++; if (wr_en !== 1'b0)      begin fails++; $display("FAIL single_wr_en_k: got %b want 0", wr_en); end
    step;
    checks++; if (wr_en !== 1'b1)      begin fails++; $display("FAIL single_wr_en_k1: got %b want 1", wr_en); end
    checks++; if (wr_addr !== 5'd5)    begin fails++; $display("FAIL single_wr_addr: got %0d want 5", wr_addr); end
    checks++; if (wr_data !== 32'hDEAD_BEEF) begin fails++; $display("FAIL single_wr_data: got %h want deadbeef", wr_data); end
    checks++; if (src0_count !== 2'd0) begin fails++; $display("FAIL single_count_k1: got %0d want 0", src0_count); end
    step;
    checks++; if (wr_en !== 1'b0)      begin fails++; $display("FAIL single_wr_en_k2: got %b want 0", wr_en); end
    checks++; if (wr_addr !== 5'd5)    begin fails++; $display("FAIL single_addr_hold: got %0d want 5", wr_addr); end
  endtask

  task automatic test_tie;
    int i0, i1;
    logic saw_full;
    do_reset;
    saw_full = 1'b0;
    src0_valid = 1'b1; src0_addr = 5'd1; src0_data = 32'h100;
    src1_valid = 1'b1; src1_addr = 5'd2; src1_data = 32'h200;
    for (int i = 0; i < 10; i++) begin
      step;
      if (acc0) src0_data = src0_data + 32'd1;
      if (acc1) src1_data = src1_data + 32'd1;
      if (src0_count == 2'd2) begin
        saw_full = 1'b1;
        checks++; if (src0_ready !== 1'b0) begin fails++; $display("FAIL tie_full_ready: got %b want 0", src0_ready); end
      end
    end
    src0_valid = 1'b0; src1_valid = 1'b0;
    repeat (6) step;
    checks++; if (saw_full !== 1'b1) begin fails++; $display("FAIL tie_src0_full: got %b want 1", saw_full); end
    checks++;
    if (log_a.size() != e0.size() + e1.size() || log_a.size() < 6) begin
      fails++; $display("FAIL tie_count: got %0d writes want %0d", log_a.size(), e0.size() + e1.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (log_a[i] !== ((i % 2 == 0) ? 5'd1 : 5'd2)) begin
          fails++; $display("FAIL tie_order: write %0d got addr %0d want %0d", i, log_a[i], (i % 2 == 0) ? 1 : 2);
        end
      end
    end
    i0 = 0; i1 = 0;
    foreach (log_a[i]) begin
      checks++;
      if (log_a[i] == 5'd1) begin
        if (i0 >= e0.size() || log_d[i] !== e0[i0]) begin fails++; $display("FAIL tie_data0: write %0d got %h", i, log_d[i]); end
        i0++;
      end else begin
        if (i1 >= e1.size() || log_d[i] !== e1[i1]) begin fails++; $display("FAIL tie_data1: write %0d got %h", i, log_d[i]); end
        i1++;
      end
    end
  endtask

  task automatic test_backpressure;
    int n1, i0, k;
    logic saw_full;
    logic [DW-1:0] want1 [3];
    want1[0] = 32'hB0; want1[1] = 32'hB1; want1[2] = 32'hB2;
    do_reset;
    n1 = 0; saw_full = 1'b0;
    src0_valid = 1'b1; src0_addr = 5'd3; src0_data = 32'hA00;
    src1_valid = 1'b1; src1_addr = 5'd4; src1_data = 32'hB0;
    for (int i = 0; i < 12; i++) begin
      step;
      if (acc0) src0_data = src0_data + 32'd1;
      if (acc1) begin
        n1++;
        src1_data = 32'hB0 + n1;
        if (n1 == 3) src1_valid = 1'b0;
      end
      if (src1_count == 2'd2) begin
        saw_full = 1'b1;
        checks++; if (src1_ready !== 1'b0) begin fails++; $display("FAIL bp_full_ready: got %b want 0", src1_ready); end
      end
    end
    src0_valid = 1'b0; src1_valid = 1'b0;
    repeat (6) step;
    checks++; if (saw_full !== 1'b1) begin fails++; $display("FAIL bp_src1_full: got %b want 1", saw_full); end
    checks++; if (n1 != 3) begin fails++; $display("FAIL bp_accepts: got %0d want 3", n1); end
    i0 = 0; k = 0;
    foreach (log_a[i]) begin
      checks++;
      if (log_a[i] == 5'd4) begin
        if (k >= 3 || log_d[i] !== want1[k]) begin fails++; $display("FAIL bp_data1: write %0d got %h slot %0d", i, log_d[i], k); end
        k++;
      end else begin
        if (i0 >= e0.size() || log_d[i] !== e0[i0]) begin fails++; $display("FAIL bp_data0: write %0d got %h", i, log_d[i]); end
        i0++;
      end
    end
    checks++; if (k != 3 || i0 != e0.size()) begin fails++; $display("FAIL bp_totals: got src1 %0d src0 %0d want 3 and %0d", k, i0, e0.size()); end
  endtask

  task automatic test_same_addr;
    do_reset;
    src0_valid = 1'b1; src0_addr = 5'd7; src0_data = 32'hA;
    src1_valid = 1'b1; src1_addr = 5'd7; src1_data = 32'hB;
    step;
    src0_valid = 1'b0; src1_valid = 1'b0;
    step;
    checks++; if (wr_en !== 1'b1 || wr_addr !== 5'd7 || wr_data !== 32'hA) begin
      fails++; $display("FAIL race_first: got en=%b addr=%0d data=%h want 1/7/a", wr_en, wr_addr, wr_data); end
    step;
    checks++; if (wr_en !== 1'b1 || wr_addr !== 5'd7 || wr_data !== 32'hB) begin
      fails++; $display("FAIL race_second: got en=%b addr=%0d data=%h want 1/7/b", wr_en, wr_addr, wr_data); end
    step;
    checks++; if (rf[7] !== 32'hB) begin fails++; $display("FAIL race_final_r7: got %h want b", rf[7]); end
    checks++; if (log_a.size() != 2) begin fails++; $display("FAIL race_writes: got %0d want 2", log_a.size()); end
  endtask

  task automatic test_reset_mid_op;
    do_reset;
    src0_valid = 1'b1; src0_addr = 5'd10; src0_data = 32'hC0;
    src1_valid = 1'b1; src1_addr = 5'd11; src1_data = 32'hD0;
    repeat (4) step;
    checks++; if (src0_count + src1_count < 3) begin fails++; $display("FAIL midrst_fill: got %0d total want >=3", src0_count + src1_count); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (src0_count !== '0 || src1_count !== '0) begin
      fails++; $display("FAIL midrst_counts: got %0d/%0d want 0/0", src0_count, src1_count); end
    checks++; if (wr_en !== 1'b0) begin fails++; $display("FAIL midrst_wr_en: got %b want 0", wr_en); end
    checks++; if (src0_ready !== 1'b1 || src1_ready !== 1'b1) begin
      fails++; $display("FAIL midrst_ready: got %b%b want 11", src0_ready, src1_ready); end
    src0_valid = 1'b0; src1_valid = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    log_a.delete(); log_d.delete();
    repeat (8) @(posedge clk);
    #1;
    checks++; if (log_a.size() != 0) begin fails++; $display("FAIL midrst_stale: got %0d writes want 0", log_a.size()); end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    test_reset;
    test_single_write;
    test_tie;
    test_backpressure;
    test_same_addr;
    test_reset_mid_op;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
